// File: rtl/cnn_layer_accel_job_fetch_ctrl.sv
// Job/fetch/pixel responder for the CNN layer accelerator quad.
// Accepts a job, requests the input map one row at a time, forwards each
// row's pixel beats to the row-buffer write port and reports completion.
// Every output comes straight from a flop so the host sees clean timing.
module cnn_layer_accel_job_fetch_ctrl #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_NUM_LANES   = 8,
  parameter int C_DIM_WIDTH   = 10
) (
  input  logic                                 clk_if,
  input  logic                                 rst_n,
  input  logic [C_DIM_WIDTH-1:0]               num_input_rows_cfg,
  input  logic [C_DIM_WIDTH-1:0]               num_input_cols_cfg,
  input  logic                                 job_start,
  output logic                                 job_accept,
  output logic                                 job_fetch_request,
  input  logic                                 job_fetch_ack,
  input  logic                                 job_fetch_complete,
  output logic                                 job_complete,
  input  logic                                 job_complete_ack,
  input  logic                                 pixel_valid,
  output logic                                 pixel_ready,
  input  logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] pixel_data,
  input  logic                                 row_buf_free,
  output logic                                 wr_en,
  output logic [C_DIM_WIDTH-1:0]               wr_row,
  output logic [C_DIM_WIDTH-1:0]               wr_col,
  output logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] wr_data,
  output logic                                 err_short_row,
  output logic                                 busy
);

  localparam int W = C_PIXEL_WIDTH * C_NUM_LANES;
  localparam logic [C_DIM_WIDTH-1:0] DIM_ZERO = '0;
  localparam logic [C_DIM_WIDTH-1:0] DIM_ONE  = {{(C_DIM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_STREAM    = 3'd2,
    S_WAIT_CMPL = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                 state_q, state_d;

  // Job geometry captured at accept; both hold (count - 1).
  logic [C_DIM_WIDTH-1:0] rows_cfg_q, rows_cfg_d;
  logic [C_DIM_WIDTH-1:0] cols_cfg_q, cols_cfg_d;

  // Position of the next beat to be written. col never passes cols_cfg,
  // so a full 2^C_DIM_WIDTH-wide row cannot wrap the counter.
  logic [C_DIM_WIDTH-1:0] row_q, row_d;
  logic [C_DIM_WIDTH-1:0] col_q, col_d;

  logic                   job_accept_q, job_accept_d;
  logic                   fetch_req_q, fetch_req_d;
  logic                   job_complete_q, job_complete_d;
  logic                   pixel_ready_q, pixel_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [C_DIM_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [C_DIM_WIDTH-1:0] wr_col_q, wr_col_d;
  logic [W-1:0]           wr_data_q, wr_data_d;
  logic                   err_short_q, err_short_d;
  logic                   busy_q, busy_d;

  logic                   beat_xfer;
  logic                   last_beat;

  assign beat_xfer = pixel_valid & pixel_ready_q;
  assign last_beat = (col_q == cols_cfg_q);

  // Next-state and next-output logic for the whole job sequence.
  always_comb begin
    state_d        = state_q;
    rows_cfg_d     = rows_cfg_q;
    cols_cfg_d     = cols_cfg_q;
    row_d          = row_q;
    col_d          = col_q;
    job_accept_d   = 1'b0;
    fetch_req_d    = fetch_req_q;
    job_complete_d = job_complete_q;
    pixel_ready_d  = pixel_ready_q;
    wr_en_d        = 1'b0;
    wr_row_d       = wr_row_q;
    wr_col_d       = wr_col_q;
    wr_data_d      = wr_data_q;
    err_short_d    = err_short_q;

    unique case (state_q)
      S_IDLE: begin
        fetch_req_d    = 1'b0;
        job_complete_d = 1'b0;
        pixel_ready_d  = 1'b0;
        if (job_start) begin
          rows_cfg_d   = num_input_rows_cfg;
          cols_cfg_d   = num_input_cols_cfg;
          row_d        = DIM_ZERO;
          col_d        = DIM_ZERO;
          err_short_d  = 1'b0;
          job_accept_d = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        if (fetch_req_q) begin
          if (job_fetch_ack) begin
            fetch_req_d   = 1'b0;
            pixel_ready_d = 1'b1;
            state_d       = S_STREAM;
          end
        end else if (row_buf_free) begin
          fetch_req_d = 1'b1;
        end
      end

      S_STREAM: begin
        if (beat_xfer) begin
          wr_en_d   = 1'b1;
          wr_row_d  = row_q;
          wr_col_d  = col_q;
          wr_data_d = pixel_data;
        end
        if (beat_xfer && last_beat) begin
          pixel_ready_d = 1'b0;
          state_d       = job_fetch_complete ? S_NEXT : S_WAIT_CMPL;
        end else begin
          if (beat_xfer) begin
            col_d = col_q + DIM_ONE;
          end
          if (job_fetch_complete) begin
            err_short_d   = 1'b1;
            pixel_ready_d = 1'b0;
            state_d       = S_NEXT;
          end
        end
      end

      S_WAIT_CMPL: begin
        pixel_ready_d = 1'b0;
        if (job_fetch_complete) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        col_d = DIM_ZERO;
        if (row_q == rows_cfg_q) begin
          job_complete_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          row_d   = row_q + DIM_ONE;
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        if (job_complete_ack) begin
          job_complete_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d        = S_IDLE;
        fetch_req_d    = 1'b0;
        job_complete_d = 1'b0;
        pixel_ready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rows_cfg_q     <= '0;
      cols_cfg_q     <= '0;
      row_q          <= '0;
      col_q          <= '0;
      job_accept_q   <= 1'b0;
      fetch_req_q    <= 1'b0;
      job_complete_q <= 1'b0;
      pixel_ready_q  <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_row_q       <= '0;
      wr_col_q       <= '0;
      wr_data_q      <= '0;
      err_short_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rows_cfg_q     <= rows_cfg_d;
      cols_cfg_q     <= cols_cfg_d;
      row_q          <= row_d;
      col_q          <= col_d;
      job_accept_q   <= job_accept_d;
      fetch_req_q    <= fetch_req_d;
      job_complete_q <= job_complete_d;
      pixel_ready_q  <= pixel_ready_d;
      wr_en_q        <= wr_en_d;
      wr_row_q       <= wr_row_d;
      wr_col_q       <= wr_col_d;
      wr_data_q      <= wr_data_d;
      err_short_q    <= err_short_d;
      busy_q         <= busy_d;
    end
  end

  assign job_accept        = job_accept_q;
  assign job_fetch_request = fetch_req_q;
  assign job_complete      = job_complete_q;
  assign pixel_ready       = pixel_ready_q;
  assign wr_en             = wr_en_q;
  assign wr_row            = wr_row_q;
  assign wr_col            = wr_col_q;
  assign wr_data           = wr_data_q;
  assign err_short_row     = err_short_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_fetch_ctrl.sv
// Directed testbench for cnn_layer_accel_job_fetch_ctrl.
// A host driver task plays the job/fetch/pixel protocol, a monitor logs
// every row-buffer write, and each test task checks its own results.
module tb_cnn_layer_accel_job_fetch_ctrl;

  localparam int PW = 16;
  localparam int NL = 8;
  localparam int DW = 10;
  localparam int W  = PW * NL;

  logic          clk_if;
  logic          rst_n;
  logic [DW-1:0] num_input_rows_cfg;
  logic [DW-1:0] num_input_cols_cfg;
  logic          job_start;
  logic          job_accept;
  logic          job_fetch_request;
  logic          job_fetch_ack;
  logic          job_fetch_complete;
  logic          job_complete;
  logic          job_complete_ack;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [W-1:0]  pixel_data;
  logic          row_buf_free;
  logic          wr_en;
  logic [DW-1:0] wr_row;
  logic [DW-1:0] wr_col;
  logic [W-1:0]  wr_data;
  logic          err_short_row;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int            req_rise;
  int            acc_cnt;
  int            cmpl_rise;
  bit            prev_req;
  bit            prev_cmpl;
  logic [DW-1:0] wr_row_log[$];
  logic [DW-1:0] wr_col_log[$];
  logic [W-1:0]  wr_data_log[$];

  cnn_layer_accel_job_fetch_ctrl #(
    .C_PIXEL_WIDTH(PW),
    .C_NUM_LANES  (NL),
    .C_DIM_WIDTH  (DW)
  ) dut (
    .clk_if            (clk_if),
    .rst_n             (rst_n),
    .num_input_rows_cfg(num_input_rows_cfg),
    .num_input_cols_cfg(num_input_cols_cfg),
    .job_start         (job_start),
    .job_accept        (job_accept),
    .job_fetch_request (job_fetch_request),
    .job_fetch_ack     (job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete      (job_complete),
    .job_complete_ack  (job_complete_ack),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_data        (pixel_data),
    .row_buf_free      (row_buf_free),
    .wr_en             (wr_en),
    .wr_row            (wr_row),
    .wr_col            (wr_col),
    .wr_data           (wr_data),
    .err_short_row     (err_short_row),
    .busy              (busy)
  );

  // Free-running 100 MHz interface clock.
  initial begin
    clk_if = 1'b0;
    forever #5 clk_if = ~clk_if;
  end

  // Log row-buffer writes and count protocol pulses seen on the outputs.
  always @(posedge clk_if) begin
    if (wr_en === 1'b1) begin
      wr_row_log.push_back(wr_row);
      wr_col_log.push_back(wr_col);
      wr_data_log.push_back(wr_data);
    end
    if (job_fetch_request === 1'b1 && !prev_req) req_rise++;
    if (job_complete === 1'b1 && !prev_cmpl) cmpl_rise++;
    if (job_accept === 1'b1) acc_cnt++;
    prev_req  = (job_fetch_request === 1'b1);
    prev_cmpl = (job_complete === 1'b1);
  end

  function automatic logic [W-1:0] pat(input int r, input int c, input int seed);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) begin
      v[k*PW +: PW] = 16'((seed << 12) ^ (r << 8) ^ (c << 4) ^ k);
    end
    return v;
  endfunction

  task automatic clear_mon();
    req_rise  = 0;
    acc_cnt   = 0;
    cmpl_rise = 0;
    wr_row_log.delete();
    wr_col_log.delete();
    wr_data_log.delete();
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  // Host side of one job; rows/cols are counts, not count-1.
  task automatic host_job(input int rows, input int cols, input int seed,
                          input bit rand_valid, input int short_row, input int short_beats,
                          input int extra_row, input int extra_beats, input int hold_free,
                          input int abort_row, input bit hold_start,
                          output int acc_seen, output int acc_after, output int err_at_accept,
                          output int timeouts, output int ready_after_extra,
                          output int req_during_hold, output int cmpl_held,
                          output int cmpl_after_ack, output int err_seen);
    int   w;
    int   sent;
    int   n_send;
    logic rdy;
    acc_seen = 0; acc_after = 0; err_at_accept = 0; timeouts = 0;
    ready_after_extra = 1; req_during_hold = 0; cmpl_held = 0;
    cmpl_after_ack = 1; err_seen = 0;
    num_input_rows_cfg = DW'(rows - 1);
    num_input_cols_cfg = DW'(cols - 1);
    job_start = 1'b1;
    tick();
    acc_seen      = int'(job_accept);
    err_at_accept = int'(err_short_row);
    if (!hold_start) job_start = 1'b0;
    num_input_rows_cfg = '1;
    num_input_cols_cfg = '1;
    tick();
    acc_after = int'(job_accept);
    for (int r = 0; r < rows; r++) begin
      w = 0;
      while (job_fetch_request !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      if (job_fetch_request !== 1'b1) begin
        timeouts++;
        return;
      end
      job_fetch_ack = 1'b1;
      tick();
      job_fetch_ack = 1'b0;
      if (r == abort_row) begin
        pixel_valid = 1'b1;
        pixel_data  = pat(r, 0, seed);
        tick();
        pixel_data  = pat(r, 1, seed);
        tick();
        pixel_valid = 1'b0;
        return;
      end
      n_send = (r == short_row) ? short_beats : cols;
      if (r == extra_row) begin
        for (int c = 0; c < extra_beats; c++) begin
          pixel_valid = 1'b1;
          pixel_data  = pat(r, c, seed);
          tick();
        end
        pixel_valid = 1'b0;
        ready_after_extra = int'(pixel_ready);
      end else begin
        sent = 0;
        w    = 0;
        while (sent < n_send && w < 2000) begin
          pixel_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
          pixel_data  = pat(r, sent, seed);
          rdy         = pixel_ready;
          tick();
          if (pixel_valid && rdy) sent++;
          w++;
        end
        pixel_valid = 1'b0;
        if (sent < n_send) begin
          timeouts++;
          return;
        end
      end
      job_fetch_complete = 1'b1;
      if (r == 0 && hold_free > 0) row_buf_free = 1'b0;
      tick();
      job_fetch_complete = 1'b0;
      if (r == 0 && hold_free > 0) begin
        for (int k = 0; k < hold_free; k++) begin
          if (job_fetch_request !== 1'b0) req_during_hold++;
          tick();
        end
        row_buf_free = 1'b1;
      end
    end
    w = 0;
    while (job_complete !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (job_complete !== 1'b1) begin
      timeouts++;
      return;
    end
    err_seen  = int'(err_short_row);
    cmpl_held = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (job_complete !== 1'b1) cmpl_held = 0;
    end
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    job_start        = 1'b0;
    cmpl_after_ack   = int'(job_complete);
  endtask

  task automatic test_reset();
    logic [W+2*DW+7:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_if);
    #1;
    outs = {job_accept, job_fetch_request, job_complete, pixel_ready, wr_en,
            wr_row, wr_col, wr_data, err_short_row, busy, 1'b0};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic_10x10();
    int a, aa, ea, to, rx, rh, ch, ca, es, mism, idx;
    clear_mon();
    host_job(10, 10, 1, 1'b0, -1, 0, -1, 0, 0, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    tick();
    n_checks++;
    if (to !== 0) begin n_fail++; $display("[TB] FAIL basic_timeout: got %0d expected 0", to); end
    n_checks++;
    if (a !== 1 || aa !== 0) begin
      n_fail++; $display("[TB] FAIL basic_accept_pulse: got %0d,%0d expected 1,0", a, aa);
    end
    n_checks++;
    if (req_rise !== 10) begin n_fail++; $display("[TB] FAIL basic_requests: got %0d expected 10", req_rise); end
    n_checks++;
    if (wr_row_log.size() !== 100) begin
      n_fail++; $display("[TB] FAIL basic_write_count: got %0d expected 100", wr_row_log.size());
    end
    mism = 0; idx = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        if (idx >= wr_row_log.size() || wr_row_log[idx] !== DW'(r) ||
            wr_col_log[idx] !== DW'(c) || wr_data_log[idx] !== pat(r, c, 1)) mism++;
        idx++;
      end
    end
    n_checks++;
    if (mism !== 0) begin n_fail++; $display("[TB] FAIL basic_write_order: got %0d bad writes expected 0", mism); end
    n_checks++;
    if (ch !== 1 || ca !== 0) begin
      n_fail++; $display("[TB] FAIL basic_complete_hold: got held=%0d after_ack=%0d expected 1,0", ch, ca);
    end
    n_checks++;
    if (es !== 0) begin n_fail++; $display("[TB] FAIL basic_err: got %0d expected 0", es); end
    n_checks++;
    if (busy !== 1'b0 || cmpl_rise !== 1) begin
      n_fail++; $display("[TB] FAIL basic_idle_after: got busy=%b cmpl=%0d expected 0,1", busy, cmpl_rise);
    end
  endtask

  task automatic test_backpressure_free();
    int a, aa, ea, to, rx, rh, ch, ca, es;
    clear_mon();
    host_job(3, 4, 2, 1'b0, -1, 0, -1, 0, 20, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    n_checks++;
    if (rh !== 0) begin n_fail++; $display("[TB] FAIL bp_req_while_full: got %0d cycles expected 0", rh); end
    n_checks++;
    if (to !== 0 || req_rise !== 3 || wr_row_log.size() !== 12) begin
      n_fail++;
      $display("[TB] FAIL bp_job: got to=%0d req=%0d wr=%0d expected 0,3,12", to, req_rise, wr_row_log.size());
    end
  endtask

  task automatic test_random_valid();
    int a, aa, ea, to, rx, rh, ch, ca, es, mism, idx;
    clear_mon();
    host_job(4, 10, 3, 1'b1, -1, 0, -1, 0, 0, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    tick();
    mism = 0; idx = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 10; c++) begin
        if (idx >= wr_row_log.size() || wr_row_log[idx] !== DW'(r) ||
            wr_col_log[idx] !== DW'(c) || wr_data_log[idx] !== pat(r, c, 3)) mism++;
        idx++;
      end
    end
    n_checks++;
    if (to !== 0 || wr_row_log.size() !== 40) begin
      n_fail++; $display("[TB] FAIL rand_count: got to=%0d wr=%0d expected 0,40", to, wr_row_log.size());
    end
    n_checks++;
    if (mism !== 0) begin n_fail++; $display("[TB] FAIL rand_order: got %0d bad writes expected 0", mism); end
  endtask

  task automatic test_short_row();
    int a, aa, ea, to, rx, rh, ch, ca, es, mism, idx, ncol;
    clear_mon();
    host_job(3, 10, 4, 1'b0, 1, 6, -1, 0, 0, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    tick();
    n_checks++;
    if (es !== 1) begin n_fail++; $display("[TB] FAIL short_err_set: got %0d expected 1", es); end
    n_checks++;
    if (to !== 0 || req_rise !== 3 || wr_row_log.size() !== 26) begin
      n_fail++;
      $display("[TB] FAIL short_counts: got to=%0d req=%0d wr=%0d expected 0,3,26", to, req_rise, wr_row_log.size());
    end
    mism = 0; idx = 0;
    for (int r = 0; r < 3; r++) begin
      ncol = (r == 1) ? 6 : 10;
      for (int c = 0; c < ncol; c++) begin
        if (idx >= wr_row_log.size() || wr_row_log[idx] !== DW'(r) ||
            wr_col_log[idx] !== DW'(c) || wr_data_log[idx] !== pat(r, c, 4)) mism++;
        idx++;
      end
    end
    n_checks++;
    if (mism !== 0) begin n_fail++; $display("[TB] FAIL short_order: got %0d bad writes expected 0", mism); end
    n_checks++;
    if (err_short_row !== 1'b1) begin
      n_fail++; $display("[TB] FAIL short_err_sticky: got %b expected 1", err_short_row);
    end
    host_job(1, 1, 5, 1'b0, -1, 0, -1, 0, 0, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    n_checks++;
    if (a !== 1 || ea !== 0 || es !== 0) begin
      n_fail++; $display("[TB] FAIL short_err_clear: got acc=%0d err=%0d,%0d expected 1,0,0", a, ea, es);
    end
  endtask

  task automatic test_extra_beats();
    int a, aa, ea, to, rx, rh, ch, ca, es, mism, idx;
    clear_mon();
    host_job(2, 10, 6, 1'b0, -1, 0, 0, 15, 0, -1, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    tick();
    n_checks++;
    if (rx !== 0) begin n_fail++; $display("[TB] FAIL extra_ready_low: got %0d expected 0", rx); end
    mism = 0; idx = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 10; c++) begin
        if (idx >= wr_row_log.size() || wr_row_log[idx] !== DW'(r) ||
            wr_col_log[idx] !== DW'(c) || wr_data_log[idx] !== pat(r, c, 6)) mism++;
        idx++;
      end
    end
    n_checks++;
    if (to !== 0 || wr_row_log.size() !== 20 || mism !== 0 || es !== 0) begin
      n_fail++;
      $display("[TB] FAIL extra_writes: got to=%0d wr=%0d bad=%0d err=%0d expected 0,20,0,0",
               to, wr_row_log.size(), mism, es);
    end
  endtask

  task automatic test_reset_mid_job();
    int a, aa, ea, to, rx, rh, ch, ca, es;
    logic [W+2*DW+7:0] outs;
    clear_mon();
    host_job(10, 10, 7, 1'b0, -1, 0, -1, 0, 0, 4, 1'b0,
             a, aa, ea, to, rx, rh, ch, ca, es);
    n_checks++;
    if (to !== 0 || busy !== 1'b1 || req_rise !== 5) begin
      n_fail++; $display("[TB] FAIL midrst_reach_row4: got to=%0d busy=%b req=%0d expected 0,1,5", to, busy, req_rise);
    end
    pixel_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    outs = {job_accept, job_fetch_request, job_complete, pixel_ready, wr_en,
            wr_row, wr_col, wr_data, err_short_row, busy, 1'b0};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got %h expected 0", outs);
    end
    pixel_valid = 1'b0;
    repeat (2) @(posedge clk_if);
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    num_input_rows_cfg = '0;
    num_input_cols_cfg = '0;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    n_checks++;
    if (job_accept !== 1'b1 || cmpl_rise !== 0) begin
      n_fail++; $display("[TB] FAIL midrst_new_accept: got acc=%b cmpl=%0d expected 1,0", job_accept, cmpl_rise);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_boundary();
    int a, aa, ea, to, rx, rh, ch, ca, es;
    clear_mon();
    host_job(1, 1, 8, 1'b0, -1, 0, -1, 0, 0, -1, 1'b1,
             a, aa, ea, to, rx, rh, ch, ca, es);
    repeat (3) tick();
    n_checks++;
    if (to !== 0 || req_rise !== 1 || wr_row_log.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL bound_counts: got to=%0d req=%0d wr=%0d expected 0,1,1", to, req_rise, wr_row_log.size());
    end
    n_checks++;
    if (wr_row_log.size() < 1 || wr_row_log[0] !== '0 || wr_col_log[0] !== '0 || wr_data_log[0] !== pat(0, 0, 8)) begin
      n_fail++; $display("[TB] FAIL bound_write: got entries=%0d expected (0,0) with pattern data", wr_row_log.size());
    end
    n_checks++;
    if (acc_cnt !== 1 || ch !== 1 || ca !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bound_single_accept: got acc=%0d held=%0d after=%0d busy=%b expected 1,1,0,0",
               acc_cnt, ch, ca, busy);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    rst_n              = 1'b0;
    num_input_rows_cfg = '0;
    num_input_cols_cfg = '0;
    job_start          = 1'b0;
    job_fetch_ack      = 1'b0;
    job_fetch_complete = 1'b0;
    job_complete_ack   = 1'b0;
    pixel_valid        = 1'b0;
    pixel_data         = '0;
    row_buf_free       = 1'b1;
    prev_req           = 1'b0;
    prev_cmpl          = 1'b0;
    clear_mon();
    test_reset();
    test_basic_10x10();
    test_backpressure_free();
    test_random_valid();
    test_short_row();
    test_extra_beats();
    test_reset_mid_job();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
